// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one downstream memory port between the instruction-fetch requester
// (read-only) and the memory-stage requester (loads/stores). Requests are
// granted and forwarded combinationally. An in-order owner FIFO records who
// issued each accepted request so every downstream response is routed back
// to its issuer. Data has priority over fetch, except that fetch wins once it
// has lost STARVE_LIMIT contended accepts in a row. A flush marks every
// outstanding entry as dropped so stale responses are silently consumed.
//
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   if_req_i/if_addr_i/if_ready_o       fetch request channel
//   if_resp_valid_o/if_rd_data_o/
//   if_resp_ready_i                     fetch response channel
//   dm_req_i/dm_addr_i/dm_wr_i/
//   dm_wr_data_i/dm_mask_i/dm_ready_o   memory-stage request channel
//   dm_resp_valid_o/dm_rd_data_o/
//   dm_resp_ready_i                     memory-stage response channel
//   mem_req_o/mem_addr_o/mem_wr_o/
//   mem_wr_data_o/mem_mask_o/
//   mem_ready_i                         downstream request channel
//   mem_resp_valid_i/mem_rd_data_i/
//   mem_resp_ready_o                    downstream response channel
//   flush_i                             pipeline flush
//   err_o                               sticky: response with no outstanding owner
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_ready_o,
  output logic        if_resp_valid_o,
  output logic [63:0] if_rd_data_o,
  input  logic        if_resp_ready_i,
  input  logic        dm_req_i,
  input  logic [63:0] dm_addr_i,
  input  logic        dm_wr_i,
  input  logic [63:0] dm_wr_data_i,
  input  logic [7:0]  dm_mask_i,
  output logic        dm_ready_o,
  output logic        dm_resp_valid_o,
  output logic [63:0] dm_rd_data_o,
  input  logic        dm_resp_ready_i,
  output logic        mem_req_o,
  output logic [63:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [63:0] mem_wr_data_o,
  output logic [7:0]  mem_mask_o,
  input  logic        mem_ready_i,
  input  logic        mem_resp_valid_i,
  input  logic [63:0] mem_rd_data_i,
  output logic        mem_resp_ready_o,
  input  logic        flush_i,
  output logic        err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  owner_e           owner_q [MAX_OUTSTANDING];
  logic             drop_q  [MAX_OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve;
  logic             err_q;

  logic can_issue;
  logic grant_fetch;
  logic grant_data;
  logic push;
  logic pop;
  logic fifo_empty;
  logic starved;

  assign fifo_empty = (count == '0);
  assign starved    = (starve == STV_W'(STARVE_LIMIT));
  // Full blocks issue even if the head pops this cycle: keeps the ready path
  // independent of the response path.
  assign can_issue  = (count < CNT_W'(MAX_OUTSTANDING)) && !flush_i;

  assign grant_fetch = if_req_i && (!dm_req_i || starved);
  assign grant_data  = dm_req_i && !grant_fetch;

  assign push  = mem_req_o && mem_ready_i;
  assign pop   = !fifo_empty && mem_resp_valid_i && mem_resp_ready_o;
  assign err_o = err_q;

  // Request path.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_req_o     = 1'b0;
    mem_addr_o    = '0;
    mem_wr_o      = 1'b0;
    mem_wr_data_o = '0;
    mem_mask_o    = '0;
    if_ready_o    = 1'b0;
    dm_ready_o    = 1'b0;
    if (grant_data) begin
      mem_req_o     = can_issue;
      mem_addr_o    = dm_addr_i;
      mem_wr_o      = dm_wr_i;
      mem_wr_data_o = dm_wr_data_i;
      mem_mask_o    = dm_mask_i;
      dm_ready_o    = can_issue && mem_ready_i;
    end else if (grant_fetch) begin
      mem_req_o     = can_issue;
      mem_addr_o    = if_addr_i;
      if_ready_o    = can_issue && mem_ready_i;
    end
  end

  // Response path: route by the owner at the FIFO head; dropped entries and
  // an empty FIFO absorb responses unconditionally.
  always_comb begin
    if_resp_valid_o  = 1'b0;
    if_rd_data_o     = '0;
    dm_resp_valid_o  = 1'b0;
    dm_rd_data_o     = '0;
    mem_resp_ready_o = 1'b1;
    if (!fifo_empty && !drop_q[rd_ptr]) begin
      if (owner_q[rd_ptr] == OWN_DATA) begin
        dm_resp_valid_o  = mem_resp_valid_i;
        dm_rd_data_o     = mem_rd_data_i;
        mem_resp_ready_o = dm_resp_ready_i;
      end else begin
        if_resp_valid_o  = mem_resp_valid_i;
        if_rd_data_o     = mem_rd_data_i;
        mem_resp_ready_o = if_resp_ready_i;
      end
    end
  end

  // NOTE: FIFO storage has no reset; entries are only read while count marks
  // them valid, and a push always rewrites both fields.
  always_ff @(posedge clk) begin
    if (push) begin
      owner_q[wr_ptr] <= grant_data ? OWN_DATA : OWN_FETCH;
      drop_q[wr_ptr]  <= 1'b0;
    end
    // Push and flush never coincide. Marking invalid slots too is harmless.
    if (flush_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) drop_q[i] <= 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      starve <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // Starvation counts only accepts of data while fetch was waiting.
      if (push && grant_data && if_req_i) begin
        if (!starved) starve <= starve + 1'b1;
      end else if (push && grant_fetch) begin
        starve <= '0;
      end
      if (fifo_empty && mem_resp_valid_i) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with fixed
// expectations plus a randomized run checked against a queue-based model.
module tb_mem_port_arbiter;

  localparam int MAXO   = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_ready_o;
  logic        if_resp_valid_o;
  logic [63:0] if_rd_data_o;
  logic        if_resp_ready_i;
  logic        dm_req_i;
  logic [63:0] dm_addr_i;
  logic        dm_wr_i;
  logic [63:0] dm_wr_data_i;
  logic [7:0]  dm_mask_i;
  logic        dm_ready_o;
  logic        dm_resp_valid_o;
  logic [63:0] dm_rd_data_o;
  logic        dm_resp_ready_i;
  logic        mem_req_o;
  logic [63:0] mem_addr_o;
  logic        mem_wr_o;
  logic [63:0] mem_wr_data_o;
  logic [7:0]  mem_mask_o;
  logic        mem_ready_i;
  logic        mem_resp_valid_i;
  logic [63:0] mem_rd_data_i;
  logic        mem_resp_ready_o;
  logic        flush_i;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .resetn(resetn),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_resp_valid_o(if_resp_valid_o), .if_rd_data_o(if_rd_data_o),
    .if_resp_ready_i(if_resp_ready_i),
    .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_wr_i(dm_wr_i),
    .dm_wr_data_i(dm_wr_data_i), .dm_mask_i(dm_mask_i), .dm_ready_o(dm_ready_o),
    .dm_resp_valid_o(dm_resp_valid_o), .dm_rd_data_o(dm_rd_data_o),
    .dm_resp_ready_i(dm_resp_ready_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_mask_o(mem_mask_o), .mem_ready_i(mem_ready_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_rd_data_i(mem_rd_data_i),
    .mem_resp_ready_o(mem_resp_ready_o),
    .flush_i(flush_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i = 1'b0; if_addr_i = '0; if_resp_ready_i = 1'b1;
    dm_req_i = 1'b0; dm_addr_i = '0; dm_wr_i = 1'b0; dm_wr_data_i = '0; dm_mask_i = '0;
    dm_resp_ready_i = 1'b1;
    mem_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rd_data_i = '0;
    flush_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    #2;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %0b want 0", mem_req_o); end
    n_checks++; if (if_ready_o !== 1'b0 || dm_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got if=%0b dm=%0b want 0/0", if_ready_o, dm_ready_o); end
    n_checks++; if (if_resp_valid_o !== 1'b0 || dm_resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got if=%0b dm=%0b want 0/0", if_resp_valid_o, dm_resp_valid_o); end
    n_checks++; if (mem_resp_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_mem_resp_ready got %0b want 1", mem_resp_ready_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err_o); end
    step();
    resetn = 1'b1;
    #2;
    n_checks++; if (mem_req_o !== 1'b0 || mem_resp_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset got req=%0b rr=%0b want 0/1", mem_req_o, mem_resp_ready_o); end
    step();
  endtask

  task automatic test_fetch_read();
    do_reset();
    if_req_i = 1'b1; if_addr_i = 64'h10000; mem_ready_i = 1'b1;
    #2;
    n_checks++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL fetch_ready got %0b want 1", if_ready_o); end
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h10000 || mem_wr_o !== 1'b0) begin
      n_fail++; $display("FAIL fetch_req got req=%0b addr=%h wr=%0b want 1/10000/0", mem_req_o, mem_addr_o, mem_wr_o); end
    step();
    if_req_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rd_data_i = 64'hDEAD;
    #2;
    n_checks++; if (if_resp_valid_o !== 1'b1 || if_rd_data_o !== 64'hDEAD) begin
      n_fail++; $display("FAIL fetch_resp got v=%0b d=%h want 1/dead", if_resp_valid_o, if_rd_data_o); end
    n_checks++; if (dm_resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL fetch_resp_dm got %0b want 0", dm_resp_valid_o); end
    step();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic exp_f;
    logic prev_f;
    do_reset();
    if_req_i = 1'b1; if_addr_i = 64'h100;
    dm_req_i = 1'b1; dm_addr_i = 64'h200;
    mem_ready_i = 1'b1;
    prev_f = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_resp_valid_i = (i > 0);
      mem_rd_data_i = 64'hA000 + 64'(i);
      exp_f = (i % 5 == 4);
      #2;
      n_checks++; if (if_ready_o !== exp_f || dm_ready_o !== !exp_f) begin
        n_fail++; $display("FAIL starve_grant c%0d got if=%0b dm=%0b want if=%0b", i, if_ready_o, dm_ready_o, exp_f); end
      n_checks++; if (mem_addr_o !== (exp_f ? 64'h100 : 64'h200)) begin
        n_fail++; $display("FAIL starve_addr c%0d got %h", i, mem_addr_o); end
      if (i > 0) begin
        n_checks++; if (if_resp_valid_o !== prev_f || dm_resp_valid_o !== !prev_f) begin
          n_fail++; $display("FAIL starve_route c%0d got if=%0b dm=%0b want if=%0b", i, if_resp_valid_o, dm_resp_valid_o, prev_f); end
      end
      prev_f = exp_f;
      step();
    end
    if_req_i = 1'b0; dm_req_i = 1'b0; mem_resp_valid_i = 1'b1;
    #2;
    n_checks++; if (if_resp_valid_o !== prev_f || dm_resp_valid_o !== !prev_f) begin
      n_fail++; $display("FAIL starve_route_last got if=%0b dm=%0b", if_resp_valid_o, dm_resp_valid_o); end
    step();
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    dm_req_i = 1'b1; dm_addr_i = 64'h300; mem_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++; if (dm_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_accept%0d got %0b want 1", i, dm_ready_o); end
      step();
    end
    #2;
    n_checks++; if (dm_ready_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL full_block got rdy=%0b req=%0b want 0/0", dm_ready_o, mem_req_o); end
    step();
    mem_resp_valid_i = 1'b1;
    #2;
    n_checks++; if (dm_ready_o !== 1'b0 || dm_resp_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL full_pop_cycle got rdy=%0b rv=%0b want 0/1", dm_ready_o, dm_resp_valid_o); end
    step();
    mem_resp_valid_i = 1'b0;
    #2;
    n_checks++; if (dm_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_resume got %0b want 1", dm_ready_o); end
    step();
    dm_req_i = 1'b0; mem_resp_valid_i = 1'b1;
    step();
    step();
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    if_req_i = 1'b1; if_addr_i = 64'h400; mem_ready_i = 1'b1;
    step();
    step();
    flush_i = 1'b1;
    #2;
    n_checks++; if (if_ready_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_accept got rdy=%0b req=%0b want 0/0", if_ready_o, mem_req_o); end
    step();
    flush_i = 1'b0; if_req_i = 1'b0; if_resp_ready_i = 1'b0; mem_resp_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++; if (mem_resp_ready_o !== 1'b1 || if_resp_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL flush_drop%0d got rr=%0b v=%0b want 1/0", i, mem_resp_ready_o, if_resp_valid_o); end
      step();
    end
    mem_resp_valid_i = 1'b0;
    #2;
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL flush_err got %0b want 0", err_o); end
    step();
    idle_inputs();
  endtask

  task automatic test_store_backpressure();
    do_reset();
    dm_req_i = 1'b1; dm_wr_i = 1'b1; dm_addr_i = 64'h10008;
    dm_wr_data_i = 64'h1122334455667788; dm_mask_i = 8'hF0; mem_ready_i = 1'b1;
    #2;
    n_checks++; if (mem_wr_o !== 1'b1 || mem_mask_o !== 8'hF0 || mem_addr_o !== 64'h10008 ||
                    mem_wr_data_o !== 64'h1122334455667788 || dm_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL store_req got wr=%0b mask=%h addr=%h data=%h rdy=%0b", mem_wr_o, mem_mask_o, mem_addr_o, mem_wr_data_o, dm_ready_o); end
    step();
    dm_req_i = 1'b0; dm_resp_ready_i = 1'b0; mem_resp_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++; if (mem_resp_ready_o !== 1'b0 || dm_resp_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL store_hold%0d got rr=%0b v=%0b want 0/1", i, mem_resp_ready_o, dm_resp_valid_o); end
      step();
    end
    dm_resp_ready_i = 1'b1;
    #2;
    n_checks++; if (mem_resp_ready_o !== 1'b1) begin n_fail++; $display("FAIL store_release got %0b want 1", mem_resp_ready_o); end
    step();
    mem_resp_valid_i = 1'b0;
    #2;
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL store_err got %0b want 0", err_o); end
    step();
    idle_inputs();
  endtask

  task automatic test_err_async_reset();
    do_reset();
    mem_resp_valid_i = 1'b1;
    #2;
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_before_edge got %0b want 0", err_o); end
    step();
    mem_resp_valid_i = 1'b0;
    #2;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set got %0b want 1", err_o); end
    step();
    #2;
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b want 1", err_o); end
    step();
    if_req_i = 1'b1; if_addr_i = 64'h500; mem_ready_i = 1'b1; if_resp_ready_i = 1'b0;
    step();
    if_req_i = 1'b0;
    #2;
    n_checks++; if (mem_resp_ready_o !== 1'b0) begin n_fail++; $display("FAIL err_outstanding got rr=%0b want 0", mem_resp_ready_o); end
    #1;
    resetn = 1'b0;
    #1;
    n_checks++; if (err_o !== 1'b0 || mem_resp_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL async_reset got err=%0b rr=%0b want 0/1", err_o, mem_resp_ready_o); end
    step();
    resetn = 1'b1;
    step();
    idle_inputs();
  endtask

  // Randomized traffic against a queue of outstanding owners.
  typedef struct {
    bit owner;  // 1 = data
    bit drop;
  } ent_t;

  task automatic test_random();
    ent_t        m_q[$];
    int          m_starve;
    bit          m_err;
    logic        can, gf, gd, e_req, e_ifr, e_dmr, e_mrr, e_ifv, e_dmv, e_wr, acc;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_mask;
    do_reset();
    m_starve = 0;
    m_err = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if_req_i         = ($urandom_range(0, 3) != 0);
      if_addr_i        = {$urandom(), $urandom()};
      dm_req_i         = ($urandom_range(0, 3) != 0);
      dm_addr_i        = {$urandom(), $urandom()};
      dm_wr_i          = $urandom_range(0, 1) == 1;
      dm_wr_data_i     = {$urandom(), $urandom()};
      dm_mask_i        = 8'($urandom());
      mem_ready_i      = ($urandom_range(0, 3) != 0);
      mem_resp_valid_i = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
      mem_rd_data_i    = {$urandom(), $urandom()};
      if_resp_ready_i  = ($urandom_range(0, 3) != 0);
      dm_resp_ready_i  = ($urandom_range(0, 3) != 0);
      flush_i          = ($urandom_range(0, 15) == 0);

      can   = (m_q.size() < MAXO) && !flush_i;
      gf    = if_req_i && (!dm_req_i || m_starve == STARVE);
      gd    = dm_req_i && !gf;
      e_req = can && (gf || gd);
      e_ifr = gf && can && mem_ready_i;
      e_dmr = gd && can && mem_ready_i;
      e_addr  = gd ? dm_addr_i : if_addr_i;
      e_wr    = gd ? dm_wr_i : 1'b0;
      e_wdata = gd ? dm_wr_data_i : 64'h0;
      e_mask  = gd ? dm_mask_i : 8'h0;
      e_mrr = 1'b1; e_ifv = 1'b0; e_dmv = 1'b0;
      if (m_q.size() > 0 && !m_q[0].drop) begin
        if (m_q[0].owner) begin e_mrr = dm_resp_ready_i; e_dmv = mem_resp_valid_i; end
        else              begin e_mrr = if_resp_ready_i; e_ifv = mem_resp_valid_i; end
      end

      #2;
      n_checks++; if (mem_req_o !== e_req || if_ready_o !== e_ifr || dm_ready_o !== e_dmr) begin
        n_fail++; $display("FAIL rnd_req c%0d got req=%0b ifr=%0b dmr=%0b want %0b/%0b/%0b", c, mem_req_o, if_ready_o, dm_ready_o, e_req, e_ifr, e_dmr); end
      if (e_req) begin
        n_checks++; if (mem_addr_o !== e_addr || mem_wr_o !== e_wr || mem_wr_data_o !== e_wdata || mem_mask_o !== e_mask) begin
          n_fail++; $display("FAIL rnd_fields c%0d got addr=%h wr=%0b data=%h mask=%h want %h/%0b/%h/%h", c, mem_addr_o, mem_wr_o, mem_wr_data_o, mem_mask_o, e_addr, e_wr, e_wdata, e_mask); end
      end
      n_checks++; if (mem_resp_ready_o !== e_mrr || if_resp_valid_o !== e_ifv || dm_resp_valid_o !== e_dmv) begin
        n_fail++; $display("FAIL rnd_resp c%0d got rr=%0b ifv=%0b dmv=%0b want %0b/%0b/%0b", c, mem_resp_ready_o, if_resp_valid_o, dm_resp_valid_o, e_mrr, e_ifv, e_dmv); end
      if (e_ifv || e_dmv) begin
        n_checks++; if ((e_ifv ? if_rd_data_o : dm_rd_data_o) !== mem_rd_data_i) begin
          n_fail++; $display("FAIL rnd_rdata c%0d got if=%h dm=%h want %h", c, if_rd_data_o, dm_rd_data_o, mem_rd_data_i); end
      end
      n_checks++; if (err_o !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d got %0b want %0b", c, err_o, m_err); end

      // Model update for the coming edge.
      acc = e_req && mem_ready_i;
      if (m_q.size() == 0 && mem_resp_valid_i) m_err = 1'b1;
      if (m_q.size() > 0 && mem_resp_valid_i && e_mrr) void'(m_q.pop_front());
      if (flush_i) foreach (m_q[k]) m_q[k].drop = 1'b1;
      if (acc) m_q.push_back('{owner: gd, drop: 1'b0});
      if (acc && gd && if_req_i) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
      else if (acc && gf) m_starve = 0;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch_read();
    test_starvation();
    test_full();
    test_flush();
    test_store_backpressure();
    test_err_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single data-memory port between the instruction-fetch requester (read-only) and the memory-stage requester (loads/stores), so a unified memory can serve both. Requests are forwarded combinationally in the grant cycle. An in-order owner FIFO tracks outstanding transactions so every response is routed back to the requester that issued it. Data side has priority, bounded by a starvation limit for fetch, and flush discards responses to pre-flush requests.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions (owner FIFO depth, ≥1).
- STARVE_LIMIT, 4: consecutive lost contended cycles after which fetch wins (≥1).
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- if_req_i / if_addr_i  in  1/64  fetch request, address.
- if_ready_o  out  1  fetch request accepted this cycle when high with if_req_i.
- if_resp_valid_o / if_rd_data_o  out  1/64  fetch response.
- if_resp_ready_i  in  1  fetch can take a response.
- dm_req_i / dm_addr_i / dm_wr_i / dm_wr_data_i / dm_mask_i  in  1/64/1/64/8  memory-stage request.
- dm_ready_o  out  1  memory-stage request accepted.
- dm_resp_valid_o / dm_rd_data_o  out  1/64  memory-stage response.
- dm_resp_ready_i  in  1  memory stage can take a response.
- mem_req_o / mem_addr_o / mem_wr_o / mem_wr_data_o / mem_mask_o  out  1/64/1/64/8  downstream request.
- mem_ready_i  in  1  downstream accepts request.
- mem_resp_valid_i / mem_rd_data_i  in  1/64  downstream response.
- mem_resp_ready_o  out  1  arbiter consumes response.
- flush_i  in  1  pipeline flush.
- err_o  out  1  sticky: response arrived with owner FIFO empty.

## Operation
- State: owner FIFO (MAX_OUTSTANDING entries of {owner, drop}; owner 0=fetch, 1=data), rd/wr pointers, count, starve counter, err flag.
- can_issue = (count < MAX_OUTSTANDING) & ~flush_i. No issue when full, even if a pop occurs the same cycle.
- Grant: only fetch requesting → fetch; only data → data; both → data unless starve == STARVE_LIMIT, then fetch.
- Granted requester's fields drive mem_*; fetch grant forces mem_wr_o=0, mem_wr_data_o=0, mem_mask_o=0. mem_req_o = can_issue & granted req. Ungranted fields/outputs are 0.
- Granted ready_o = can_issue & mem_ready_i; other ready_o = 0.
- Accept (mem_req_o & mem_ready_i): push {owner, drop=0}.
- Starve: +1 (saturating at STARVE_LIMIT) on each accept of data while if_req_i high; cleared on fetch accept; unchanged otherwise.
- Every accepted request (read or write) yields exactly one downstream response, in order.
- Head entry, FIFO non-empty: drop=1 → mem_resp_ready_o=1, pop, nothing forwarded. drop=0 → owner's resp_valid_o = mem_resp_valid_i, rd_data_o = mem_rd_data_i; mem_resp_ready_o = owner's resp_ready_i; pop on mem_resp_valid_i & mem_resp_ready_o.
- FIFO empty: mem_resp_ready_o=1; mem_resp_valid_i sets err_o (sticky until reset).
- flush_i: all valid entries get drop=1 that cycle (including the head if not popped); no new accept that cycle. A pop of the head in the flush cycle still forwards (drop sampled before update).
- Simultaneous push and pop: count unchanged, both pointers advance, pointers wrap at MAX_OUTSTANDING.

## Timing
- Request path: zero latency, combinational grant to mem_req_o.
- Response path: combinational routing, zero added latency.
- FIFO/counter updates on rising clk edge.
- Reset (async, any time): count=0, pointers=0, starve=0, err_o=0; outstanding transactions forgotten. During and after reset: mem_req_o=0, both ready_o=0 unless requests present, both resp_valid_o=0, mem_resp_ready_o=1.

## Test plan
- Fetch-only read 0x10000, mem_ready_i=1, response 0xDEAD next cycle → if_ready_o=1 in cycle 0, mem_wr_o=0; if_resp_valid_o=1 with 0xDEAD in cycle 1, dm_resp_valid_o=0.
- Both request every cycle, downstream always ready/responding, STARVE_LIMIT=4 → grants D,D,D,D,F,D,D,D,D,F…; responses routed to matching owner.
- MAX_OUTSTANDING=2, two data accepts, no responses → third cycle dm_ready_o=0, mem_req_o=0; after one response, issue resumes next cycle.
- Two outstanding fetches, flush_i one cycle, then two responses → both consumed with mem_resp_ready_o=1, if_resp_valid_o stays 0; new request in flush cycle not accepted.
- Data store 0x10008 mask 0xF0 with dm_resp_ready_i=0 on its ack → mem_resp_ready_o=0 and entry held until dm_resp_ready_i=1.
- mem_resp_valid_i with FIFO empty → err_o=1 next cycle, stays 1; async resetn low mid-transaction → count=0, err_o=0 immediately.
